// File: rtl/ahb_pkg.sv
// Shared AHB types and constants for the response multiplexer and its default subordinate.
package ahb_pkg;

  localparam int unsigned HTRANS_W = 2;

  typedef enum logic [HTRANS_W-1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_t;

endpackage

// File: rtl/ahb_default_subord.sv
// Default subordinate: two-cycle ERROR response for active transfers to unmapped addresses.
// Compiled only when AHB_DEFAULT_SUBORD_EN is defined.
`ifdef AHB_DEFAULT_SUBORD_EN
module ahb_default_subord
  import ahb_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_hready,
  input  logic i_unmapped_req,
  input  logic i_dtrans_active,
  output logic o_hreadyout_c,
  output logic o_hresp_c
);

  ds_state_t r_state;
  ds_state_t w_next;
  logic      w_start;

  // A new error sequence starts only when an unmapped NONSEQ/SEQ is actually captured.
  assign w_start = i_hready && i_unmapped_req;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= DS_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      DS_IDLE: if (w_start) w_next = DS_ERR1;
      DS_ERR1: w_next = DS_ERR2;
      DS_ERR2: w_next = w_start ? DS_ERR1 : DS_IDLE;
      default: w_next = DS_IDLE;
    endcase
  end

  // ERROR is only signalled while an active transfer owns the data phase.
  always_comb begin
    o_hreadyout_c = 1'b1;
    o_hresp_c     = HRESP_OKAY;
    case (r_state)
      DS_ERR1: begin
        o_hreadyout_c = ~i_dtrans_active;
        o_hresp_c     = i_dtrans_active ? HRESP_ERROR : HRESP_OKAY;
      end
      DS_ERR2: begin
        o_hreadyout_c = 1'b1;
        o_hresp_c     = i_dtrans_active ? HRESP_ERROR : HRESP_OKAY;
      end
      default: begin
        o_hreadyout_c = 1'b1;
        o_hresp_c     = HRESP_OKAY;
      end
    endcase
  end

endmodule
`endif

// File: rtl/ahb_resp_mux.sv
// AHB data-phase response mux: registers the decoder select and routes the owner's response.
// AHB_DEFAULT_SUBORD_EN enables the ERROR-answering default subordinate; otherwise unmapped is OKAY.
module ahb_resp_mux
  import ahb_pkg::*;
#(
  parameter int unsigned NUM_SUBORD = 3,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                             Hclk,
  input  logic                             Hreset,
  input  logic [NUM_SUBORD-1:0]            Hsel,
  input  logic [HTRANS_W-1:0]              Htrans,
  input  logic [NUM_SUBORD*DATA_WIDTH-1:0] Hrdata_s,
  input  logic [NUM_SUBORD-1:0]            Hreadyout_s,
  input  logic [NUM_SUBORD-1:0]            Hresp_s,
  output logic [DATA_WIDTH-1:0]            Hrdata,
  output logic                             Hready,
  output logic                             Hresp
);

  logic [NUM_SUBORD-1:0] r_dsel;
  logic                  r_dtrans_active;
  logic                  w_htrans_active;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_ready;
  logic                  w_resp;
  logic                  w_ds_ready;
  logic                  w_ds_resp;

  assign w_htrans_active = htrans_t'(Htrans) inside {NONSEQ, SEQ};

  // Address phase is captured only when the current data phase completes.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      r_dsel          <= '0;
      r_dtrans_active <= 1'b0;
    end else if (w_ready) begin
      r_dsel          <= Hsel;
      r_dtrans_active <= w_htrans_active;
    end
  end

`ifdef AHB_DEFAULT_SUBORD_EN
  logic w_unmapped_req;

  assign w_unmapped_req = (Hsel == '0) && w_htrans_active;

  ahb_default_subord u_default_subord (
    .i_clk           (Hclk),
    .i_rst           (Hreset),
    .i_hready        (w_ready),
    .i_unmapped_req  (w_unmapped_req),
    .i_dtrans_active (r_dtrans_active),
    .o_hreadyout_c   (w_ds_ready),
    .o_hresp_c       (w_ds_resp)
  );
`else
  logic w_unused;

  assign w_unused   = &{1'b0, r_dtrans_active};
  assign w_ds_ready = 1'b1;
  assign w_ds_resp  = HRESP_OKAY;
`endif

  // Walk downward so the lowest set select bit ends up owning the data phase.
  always_comb begin
    w_rdata = '0;
    w_ready = w_ds_ready;
    w_resp  = w_ds_resp;
    for (int i = int'(NUM_SUBORD) - 1; i >= 0; i--) begin
      if (r_dsel[i]) begin
        w_rdata = Hrdata_s[i*DATA_WIDTH +: DATA_WIDTH];
        w_ready = Hreadyout_s[i];
        w_resp  = Hresp_s[i];
      end
    end
  end

  assign Hrdata = w_rdata;
  assign Hready = w_ready;
  assign Hresp  = w_resp;

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Self-checking bench for ahb_resp_mux: directed scenarios plus randomized traffic vs a reference model.
module tb_ahb_resp_mux;
  import ahb_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned DW = 32;
`ifdef AHB_DEFAULT_SUBORD_EN
  localparam bit DS_EN = 1'b1;
`else
  localparam bit DS_EN = 1'b0;
`endif

  logic            Hclk = 1'b0;
  logic            Hreset = 1'b1;
  logic [N-1:0]    Hsel = '0;
  logic [1:0]      Htrans = 2'b00;
  logic [N*DW-1:0] Hrdata_s = '0;
  logic [N-1:0]    Hreadyout_s = '1;
  logic [N-1:0]    Hresp_s = '0;
  logic [DW-1:0]   Hrdata;
  logic            Hready;
  logic            Hresp;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: which subordinate owns the data phase (-1 = none) and
  // how many error cycles remain for an unmapped active transfer.
  int m_owner = -1;
  int m_err   = 0;

  always #5 Hclk = ~Hclk;

  ahb_resp_mux #(.NUM_SUBORD(N), .DATA_WIDTH(DW)) dut (
    .Hclk        (Hclk),
    .Hreset      (Hreset),
    .Hsel        (Hsel),
    .Htrans      (Htrans),
    .Hrdata_s    (Hrdata_s),
    .Hreadyout_s (Hreadyout_s),
    .Hresp_s     (Hresp_s),
    .Hrdata      (Hrdata),
    .Hready      (Hready),
    .Hresp       (Hresp)
  );

  function automatic int lowest_sel(input logic [N-1:0] s);
    for (int i = 0; i < int'(N); i++) if (s[i]) return i;
    return -1;
  endfunction

  function automatic void model_out(output logic [DW-1:0] d, output logic r, output logic p);
    if (m_owner >= 0) begin
      d = Hrdata_s[m_owner*DW +: DW];
      r = Hreadyout_s[m_owner];
      p = Hresp_s[m_owner];
    end else begin
      d = '0;
      r = (m_err != 2);
      p = (m_err != 0);
    end
  endfunction

  always @(posedge Hclk) begin
    logic [DW-1:0] d;
    logic r, p;
    model_out(d, r, p);
    if (Hreset) begin
      m_owner = -1;
      m_err   = 0;
    end else if (r) begin
      m_owner = lowest_sel(Hsel);
      m_err   = (m_owner < 0 && Htrans[1] && DS_EN) ? 2 : 0;
    end else if (m_err == 2) begin
      m_err = 1;
    end
  end

  task automatic drive_random();
    int k;
    k = int'($urandom_range(0, 9));
    if (k < 2)       Hsel = '0;
    else if (k < 9)  Hsel = N'(1) << $urandom_range(0, N - 1);
    else             Hsel = N'($urandom);
    Htrans = 2'($urandom);
    Hrdata_s = {$urandom(), $urandom(), $urandom()};
    for (int i = 0; i < int'(N); i++) Hreadyout_s[i] = ($urandom_range(0, 3) != 0);
    Hresp_s = N'($urandom);
  endtask

  task automatic test_reset();
    drive_random();
    Hreset = 1'b1;
    @(negedge Hclk); #1;
    n_cmp++; if (Hready !== 1'b1) begin n_err++; $display("FAIL reset_hready: got %b want 1", Hready); end
    n_cmp++; if (Hresp !== 1'b0) begin n_err++; $display("FAIL reset_hresp: got %b want 0", Hresp); end
    n_cmp++; if (Hrdata !== '0) begin n_err++; $display("FAIL reset_hrdata: got %h want 0", Hrdata); end
    Hreset = 1'b0; Hsel = '0; Htrans = IDLE; Hreadyout_s = '1; Hresp_s = '0;
    @(negedge Hclk);
  endtask

  task automatic test_routed_read();
    Hsel = 3'b010; Htrans = NONSEQ; Hreadyout_s = 3'b111; Hresp_s = '0;
    @(negedge Hclk);
    Hsel = '0; Htrans = IDLE;
    Hrdata_s = {$urandom(), 32'hDEAD_BEEF, $urandom()};
    #1;
    n_cmp++; if (Hrdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL routed_hrdata: got %h want deadbeef", Hrdata); end
    n_cmp++; if (Hresp !== 1'b0) begin n_err++; $display("FAIL routed_hresp: got %b want 0", Hresp); end
    n_cmp++; if (Hready !== 1'b1) begin n_err++; $display("FAIL routed_hready: got %b want 1", Hready); end
  endtask

  task automatic test_wait_state();
    logic [DW-1:0] d2, d0;
    d2 = $urandom(); d0 = $urandom();
    @(negedge Hclk);
    Hsel = 3'b100; Htrans = NONSEQ; Hreadyout_s = 3'b111;
    @(negedge Hclk);
    Hsel = 3'b001; Htrans = NONSEQ; Hreadyout_s = 3'b011;
    Hrdata_s = {d2, 32'h1111_1111, d0};
    #1;
    n_cmp++; if (Hready !== 1'b0) begin n_err++; $display("FAIL wait1_hready: got %b want 0", Hready); end
    n_cmp++; if (Hrdata !== d2) begin n_err++; $display("FAIL wait1_hrdata: got %h want %h", Hrdata, d2); end
    @(negedge Hclk); #1;
    n_cmp++; if (Hready !== 1'b0) begin n_err++; $display("FAIL wait2_hready: got %b want 0", Hready); end
    n_cmp++; if (Hrdata !== d2) begin n_err++; $display("FAIL wait2_hrdata: got %h want %h", Hrdata, d2); end
    Hreadyout_s = 3'b111;
    #1;
    n_cmp++; if (Hready !== 1'b1) begin n_err++; $display("FAIL wait3_hready: got %b want 1", Hready); end
    n_cmp++; if (Hrdata !== d2) begin n_err++; $display("FAIL wait3_hrdata: got %h want %h", Hrdata, d2); end
    @(negedge Hclk);
    Hsel = '0; Htrans = IDLE; Hreadyout_s = 3'b110;
    #1;
    n_cmp++; if (Hrdata !== d0) begin n_err++; $display("FAIL newsel_hrdata: got %h want %h", Hrdata, d0); end
    n_cmp++; if (Hready !== 1'b0) begin n_err++; $display("FAIL newsel_hready: got %b want 0", Hready); end
    @(negedge Hclk);
    Hreadyout_s = 3'b111;
    @(negedge Hclk);
  endtask

  task automatic test_unmapped();
    logic er, ep;
    Hsel = '0; Htrans = NONSEQ; Hreadyout_s = '1; Hresp_s = '1;
    @(negedge Hclk);
    Htrans = IDLE; Hrdata_s = {$urandom(), $urandom(), $urandom()};
    #1;
    er = ~DS_EN; ep = DS_EN;
    n_cmp++; if (Hready !== er) begin n_err++; $display("FAIL unm_c1_hready: got %b want %b", Hready, er); end
    n_cmp++; if (Hresp !== ep) begin n_err++; $display("FAIL unm_c1_hresp: got %b want %b", Hresp, ep); end
    n_cmp++; if (Hrdata !== '0) begin n_err++; $display("FAIL unm_c1_hrdata: got %h want 0", Hrdata); end
    @(negedge Hclk); #1;
    n_cmp++; if (Hready !== 1'b1) begin n_err++; $display("FAIL unm_c2_hready: got %b want 1", Hready); end
    n_cmp++; if (Hresp !== ep) begin n_err++; $display("FAIL unm_c2_hresp: got %b want %b", Hresp, ep); end
    @(negedge Hclk); #1;
    n_cmp++; if (Hready !== 1'b1 || Hresp !== 1'b0) begin n_err++; $display("FAIL unm_c3_okay: got ready=%b resp=%b want ready=1 resp=0", Hready, Hresp); end
    // Back-to-back unmapped NONSEQ then SEQs
    Htrans = NONSEQ;
    for (int k = 0; k < 4; k++) begin
      @(negedge Hclk);
      Htrans = (k == 3) ? IDLE : SEQ;
      #1;
      er = DS_EN ? (k % 2 == 1) : 1'b1;
      n_cmp++; if (Hready !== er) begin n_err++; $display("FAIL b2b_hready[%0d]: got %b want %b", k, Hready, er); end
      n_cmp++; if (Hresp !== ep) begin n_err++; $display("FAIL b2b_hresp[%0d]: got %b want %b", k, Hresp, ep); end
    end
    @(negedge Hclk); #1;
    n_cmp++; if (Hready !== 1'b1 || Hresp !== 1'b0) begin n_err++; $display("FAIL b2b_end_okay: got ready=%b resp=%b want ready=1 resp=0", Hready, Hresp); end
  endtask

  task automatic test_unmapped_idle();
    for (int k = 0; k < 2; k++) begin
      Hsel = '0; Htrans = (k == 0) ? IDLE : BUSY;
      @(negedge Hclk); #1;
      n_cmp++; if (Hready !== 1'b1 || Hresp !== 1'b0 || Hrdata !== '0) begin
        n_err++; $display("FAIL unm_idle[%0d]: got ready=%b resp=%b data=%h want 1/0/0", k, Hready, Hresp, Hrdata);
      end
    end
    Htrans = IDLE;
  endtask

  task automatic test_reset_mid_error();
    logic er;
    Hsel = '0; Htrans = NONSEQ;
    @(negedge Hclk);
    Htrans = SEQ;
    #1;
    er = ~DS_EN;
    n_cmp++; if (Hready !== er) begin n_err++; $display("FAIL rst_err_pre_hready: got %b want %b", Hready, er); end
    Hreset = 1'b1;
    @(negedge Hclk);
    Hreset = 1'b0; Htrans = IDLE;
    #1;
    n_cmp++; if (Hready !== 1'b1 || Hresp !== 1'b0 || Hrdata !== '0) begin
      n_err++; $display("FAIL rst_err_post: got ready=%b resp=%b data=%h want 1/0/0", Hready, Hresp, Hrdata);
    end
    @(negedge Hclk); #1;
    n_cmp++; if (Hready !== 1'b1 || Hresp !== 1'b0) begin n_err++; $display("FAIL rst_err_idle: got ready=%b resp=%b want 1/0", Hready, Hresp); end
  endtask

  task automatic test_random();
    logic [DW-1:0] ed;
    logic er, ep;
    for (int c = 0; c < 500; c++) begin
      @(negedge Hclk);
      drive_random();
      Hreset = ($urandom_range(0, 39) == 0);
      #1;
      model_out(ed, er, ep);
      n_cmp++; if (Hready !== er) begin n_err++; $display("FAIL rand_hready[%0d]: got %b want %b", c, Hready, er); end
      n_cmp++; if (Hresp !== ep) begin n_err++; $display("FAIL rand_hresp[%0d]: got %b want %b", c, Hresp, ep); end
      n_cmp++; if (Hrdata !== ed) begin n_err++; $display("FAIL rand_hrdata[%0d]: got %h want %h", c, Hrdata, ed); end
    end
    @(negedge Hclk);
    Hreset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_routed_read();
    test_wait_state();
    test_unmapped();
    test_unmapped_idle();
    test_reset_mid_error();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_resp_mux.md
Name: ahb_resp_mux

Overview:
Data-phase response multiplexer directly downstream of the address decoder.
- Registers the decoder's one-hot select at the end of each address phase.
- Routes the selected subordinate's read data, ready and response back to the manager.
- Includes a built-in default subordinate that answers transfers to unmapped addresses.
- Its Hready output is the system-wide HREADY and is fed back to the decoder and to all subordinates.

Parameters:
- NUM_SUBORD, 3, number of subordinates; must equal decoder Hsel width.
- DATA_WIDTH, 32, read data width in bits.

Ports:
- Hclk  input  1  system clock, rising-edge active.
- Hreset  input  1  synchronous, active-high reset.
- Hsel  input  NUM_SUBORD  one-hot address-phase select from the decoder.
- Htrans  input  2  manager transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- Hrdata_s  input  NUM_SUBORD*DATA_WIDTH  packed subordinate read data; slice i belongs to subordinate i.
- Hreadyout_s  input  NUM_SUBORD  per-subordinate HREADYOUT.
- Hresp_s  input  NUM_SUBORD  per-subordinate HRESP (0 OKAY, 1 ERROR).
- Hrdata  output  DATA_WIDTH  muxed read data to the manager.
- Hready  output  1  global HREADY.
- Hresp  output  1  muxed response.

Behaviour:
- Interface: one clock Hclk; Hreset is synchronous and active-high.
- Address-phase capture:
  - Happens on the Hclk edge when Hready==1.
  - Registers dsel <= Hsel and dtrans_active <= Htrans[1].
  - When Hready==0, dsel and dtrans_active hold.
- Multiple Hsel bits set: the lowest index wins. This is not legal decoder output.
- Routing:
  - If dsel has a bit i set, Hrdata = slice i of Hrdata_s, Hready = Hreadyout_s[i], Hresp = Hresp_s[i].
  - Routing is combinational from the registers, so there is zero added latency.
- Default subordinate (dsel == 0), FSM with states DS_IDLE, DS_ERR1, DS_ERR2:
  - DS_IDLE: Hready=1, Hresp=0, Hrdata=0. Goes to DS_ERR1 on a capture with Hsel==0 and Htrans[1]==1.
  - DS_ERR1: Hready=0, Hresp=1. Always goes to DS_ERR2 on the next edge.
  - DS_ERR2: Hready=1, Hresp=1. On the next edge, goes to DS_ERR1 if a new unmapped NONSEQ/SEQ is captured, otherwise DS_IDLE.
  - An unmapped IDLE/BUSY transfer gives a zero-wait OKAY and stays in DS_IDLE.
- Hrdata is 0 whenever the default subordinate owns the data phase.
- Reset (any cycle, including mid-wait-state or mid-error): next edge gives dsel=0, dtrans_active=0, FSM=DS_IDLE.
  - Outputs after reset: Hready=1, Hresp=0, Hrdata=0.
- Subordinate wait states (Hreadyout_s[i]==0) stall address capture. The next Hsel is held off until Hready returns to 1.

Optional Feature:
- Macro AHB_DEFAULT_SUBORD_EN.
- Defined: the default-subordinate ERROR FSM exists as described above.
- Undefined: the FSM is not compiled. Every unmapped data phase, including NONSEQ/SEQ, returns a zero-wait OKAY (Hready=1, Hresp=0, Hrdata=0).

Decomposition:
- Shared package ahb_pkg holds:
  - htrans_t enum (IDLE, BUSY, NONSEQ, SEQ).
  - HRESP_OKAY / HRESP_ERROR constants.
  - ds_state_t enum (DS_IDLE, DS_ERR1, DS_ERR2).
- Natural sub-module: ahb_default_subord. It holds the FSM and drives Hreadyout/Hresp for the unmapped case, and is instantiated only under AHB_DEFAULT_SUBORD_EN.
- The mux and select registers stay in ahb_resp_mux.

Test Plan:
1. Reset: assert Hreset one cycle with all inputs driven randomly -> next cycle Hready=1, Hresp=0, Hrdata=0.
2. Routed read:
   - Address phase Hsel=3'b010, Htrans=NONSEQ, Hready=1.
   - Next cycle, slice1 data 32'hDEAD_BEEF with Hreadyout_s=3'b111 -> Hrdata=32'hDEAD_BEEF, Hresp=0 in that cycle.
3. Wait state:
   - Subordinate 2 selected; Hreadyout_s[2]=0 for 2 cycles, then 1.
   - Required: Hready=0,0,1.
   - A new Hsel=3'b001 presented during the wait is ignored until the cycle where Hready=1, and dsel updates only on that edge.
4. Unmapped error (AHB_DEFAULT_SUBORD_EN defined): Hsel=0, Htrans=NONSEQ -> data phase Hready=0/Hresp=1, then Hready=1/Hresp=1, then idle OKAY.
   - Back-to-back unmapped SEQ gives ERR1, ERR2, ERR1, ERR2.
5. Unmapped IDLE: Hsel=0, Htrans=IDLE -> next cycle Hready=1, Hresp=0. Same for NONSEQ with the macro undefined.
6. Reset mid-error: assert Hreset while in DS_ERR1 -> next cycle DS_IDLE, Hready=1, Hresp=0.
